// File: rtl/noise_gate_pkg.sv
// Shared types and helpers for the noise gate: gain state encoding, unity gain and |x| saturation.
package noise_gate_pkg;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } gate_state_t;

    function automatic int unsigned gain_unity(input int unsigned frac);
        return 32'd1 << frac;
    endfunction

    // |x| with the one unrepresentable magnitude (-32768) pinned to full scale.
    function automatic logic [15:0] abs_sat16(input logic signed [15:0] x);
        if (x == 16'sh8000)
            return 16'h7fff;
        else if (x[15])
            return 16'(-x);
        else
            return 16'(x);
    endfunction

endpackage

// File: rtl/noise_gate_envelope.sv
// Envelope follower: one-pole smoothing of |signal_in|; env_next is the combinational update.
module noise_gate_envelope
    import noise_gate_pkg::*;
#(
    parameter int unsigned ENV_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic signed [15:0] signal_in,
    output logic        [15:0] env_next
);

    logic        [15:0] env;
    logic        [15:0] mag;
    logic signed [16:0] diff;
    logic signed [16:0] delta;
    logic signed [16:0] sum;

    always_comb begin
        mag   = abs_sat16(signal_in);
        diff  = $signed({1'b0, mag}) - $signed({1'b0, env});
        delta = diff >>> ENV_SHIFT;
        sum   = $signed({1'b0, env}) + delta;
        // Sum stays within 0..32767 by construction; the clamp only guards the register range.
        if (sum[16])
            env_next = '0;
        else if (sum[15])
            env_next = 16'h7fff;
        else
            env_next = sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            env <= '0;
        else if (in_valid)
            env <= env_next;
    end

endmodule

// File: rtl/noise_gate.sv
// Noise gate ahead of the overdrive: envelope-driven gain FSM plus ramped-gain multiply, latency 2.
// Define NOISE_GATE_HYSTERESIS_EN to close at 75% of the open threshold instead of at it.
module noise_gate
    import noise_gate_pkg::*;
#(
    parameter int unsigned ENV_SHIFT    = 4,
    parameter int unsigned GAIN_FRAC    = 8,
    parameter int unsigned ATTACK_STEP  = 32,
    parameter int unsigned RELEASE_STEP = 4,
    parameter int unsigned HOLD_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [15:0]       signal_in,
    input  logic signed [15:0]       threshold,
    input  logic        [HOLD_W-1:0] hold_samples,
    output logic signed [15:0]       signal_out,
    output logic                     out_valid,
    output logic                     gate_open
);

    localparam int unsigned GW = GAIN_FRAC + 1;
    localparam int unsigned PW = 16 + GW + 1;
    localparam logic [GW-1:0] UNITY       = GW'(gain_unity(GAIN_FRAC));
    localparam logic [GW:0]   STEP_A      = (GW+1)'(ATTACK_STEP);
    localparam logic [GW-1:0] STEP_R      = GW'(RELEASE_STEP);
    localparam logic [GW-1:0] ATTACK_GAIN = (ATTACK_STEP >= gain_unity(GAIN_FRAC)) ? UNITY : GW'(ATTACK_STEP);
    localparam logic signed [PW-1:0] OUT_MAX = PW'(32767);
    localparam logic signed [PW-1:0] OUT_MIN = PW'(-32768);

    gate_state_t              state, state_next;
    logic        [GW-1:0]     gain, gain_next;
    logic        [HOLD_W-1:0] hold_cnt, hold_next;
    logic        [GW:0]       sum_a;
    logic        [15:0]       env_next, open_thr, close_thr;
    logic                     above_open, above_close;
    logic signed [15:0]       sample_q;
    logic                     valid_q;
    logic signed [PW-1:0]     product, scaled;

    noise_gate_envelope #(.ENV_SHIFT(ENV_SHIFT)) u_envelope (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .signal_in(signal_in),
        .env_next (env_next)
    );

    always_comb begin
        open_thr = threshold[15] ? '0 : threshold;
`ifdef NOISE_GATE_HYSTERESIS_EN
        close_thr = open_thr - (open_thr >> 2);
`else
        close_thr = open_thr;
`endif
        above_open  = (env_next >= open_thr);
        above_close = (env_next >= close_thr);
    end

    always_comb begin
        state_next = state;
        gain_next  = gain;
        hold_next  = hold_cnt;
        sum_a      = {1'b0, gain} + STEP_A;
        case (state)
            CLOSED: begin
                if (above_open) begin
                    state_next = ATTACK;
                    gain_next  = ATTACK_GAIN;
                end else begin
                    gain_next = '0;
                end
            end
            ATTACK: begin
                if (sum_a >= {1'b0, UNITY}) begin
                    gain_next  = UNITY;
                    state_next = OPEN;
                end else begin
                    gain_next = sum_a[GW-1:0];
                end
            end
            OPEN: begin
                gain_next = UNITY;
                if (!above_close) begin
                    state_next = HOLD;
                    hold_next  = hold_samples;
                end
            end
            HOLD: begin
                gain_next = UNITY;
                if (above_open)
                    state_next = OPEN;
                else if (hold_cnt == '0)
                    state_next = RELEASE;
                else
                    hold_next = hold_cnt - HOLD_W'(1);
            end
            RELEASE: begin
                if (above_open) begin
                    state_next = ATTACK;
                end else if (gain <= STEP_R) begin
                    gain_next  = '0;
                    state_next = CLOSED;
                end else begin
                    gain_next = gain - STEP_R;
                end
            end
            default: begin
                state_next = CLOSED;
                gain_next  = '0;
            end
        endcase
    end

    // gain is only updated on accepted samples, so it still belongs to sample_q at stage 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLOSED;
            gain      <= '0;
            hold_cnt  <= '0;
            sample_q  <= '0;
            gate_open <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                state     <= state_next;
                gain      <= gain_next;
                hold_cnt  <= hold_next;
                sample_q  <= signal_in;
                gate_open <= (state_next != CLOSED);
            end
        end
    end

    always_comb begin
        product = sample_q * $signed({1'b0, gain});
        scaled  = product >>> GAIN_FRAC;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            signal_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= valid_q;
            if (valid_q) begin
                if (scaled > OUT_MAX)
                    signal_out <= 16'sh7fff;
                else if (scaled < OUT_MIN)
                    signal_out <= 16'sh8000;
                else
                    signal_out <= scaled[15:0];
            end
        end
    end

endmodule
